// File: rtl/rv_decode_pkg.sv
// Shared types for the RISC-V decode stage: format codes, base opcodes and
// the decoded-entry record held in the stage's buffer registers.
package rv_decode_pkg;

  // Widest supported XLEN; narrower builds use the low bits of imm.
  localparam int IMM_MAX = 64;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    fmt_e               fmt;
    logic [IMM_MAX-1:0] imm;
    logic               illegal;
  } entry_t;

  // Raw fields are passed through even for illegal words.
  function automatic entry_t make_entry(input logic [31:0] instr,
                                        input fmt_e fmt,
                                        input logic [IMM_MAX-1:0] imm,
                                        input logic illegal);
    entry_t e;
    e.opcode  = instr[6:0];
    e.rd      = instr[11:7];
    e.funct3  = instr[14:12];
    e.rs1     = instr[19:15];
    e.rs2     = instr[24:20];
    e.funct7  = instr[31:25];
    e.fmt     = fmt;
    e.imm     = imm;
    e.illegal = illegal;
    return e;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational format classifier and immediate generator for one
// 32-bit RISC-V instruction word.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FLAG_SYSTEM = 1
) (
  input  logic [31:0]     instr,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    fmt = FMT_ILL;
    case (instr[6:0])
      OP_R:                      fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:  fmt = FMT_I;
      OP_STORE:                  fmt = FMT_S;
      OP_BRANCH:                 fmt = FMT_B;
      OP_LUI, OP_AUIPC:          fmt = FMT_U;
      OP_JAL:                    fmt = FMT_J;
      OP_SYSTEM:                 fmt = (FLAG_SYSTEM != 0) ? FMT_I : FMT_ILL;
      default:                   fmt = FMT_ILL;
    endcase
    // Compressed/reserved encodings never reach a legal format.
    if (instr[1:0] != 2'b11) begin
      fmt = FMT_ILL;
    end
  end

  // Every immediate sign-extends cleanly from bit 31 of a 32-bit value,
  // so widen once at the end for XLEN=64.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

  assign illegal = (fmt == FMT_ILL);

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RISC-V decode stage: combinational decode feeding a main +
// skid register pair, with a registered in_ready for full throughput.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FLAG_SYSTEM = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output fmt_e            out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  fmt_e               dec_fmt;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_illegal;
  logic [IMM_MAX-1:0] dec_imm_wide;
  entry_t             dec_entry;

  entry_t main_reg, main_next;
  entry_t skid_reg, skid_next;
  logic   main_valid_reg, main_valid_next;
  logic   skid_valid_reg, skid_valid_next;
  logic   accept;
  logic   pop;

  rv_imm_gen #(
    .XLEN        (XLEN),
    .FLAG_SYSTEM (FLAG_SYSTEM)
  ) u_imm_gen (
    .instr   (in_instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec_imm_wide             = '0;
    dec_imm_wide[XLEN-1:0]   = dec_imm;
    dec_entry                = make_entry(in_instr, dec_fmt, dec_imm_wide, dec_illegal);
  end

  // in_ready is a flop output: the stage can always absorb one more word
  // while the skid slot is free.
  assign in_ready = !skid_valid_reg;
  assign accept   = in_valid && in_ready && !flush;
  assign pop      = main_valid_reg && out_ready;

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;

    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg) begin
      // Skid is never occupied while main is empty.
      if (accept) begin
        main_next       = dec_entry;
        main_valid_next = 1'b1;
      end
    end else if (pop) begin
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_next       = dec_entry;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_next       = dec_entry;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  assign out_valid   = main_valid_reg;
  assign out_opcode  = main_reg.opcode;
  assign out_rd      = main_reg.rd;
  assign out_rs1     = main_reg.rs1;
  assign out_rs2     = main_reg.rs2;
  assign out_funct3  = main_reg.funct3;
  assign out_funct7  = main_reg.funct7;
  assign out_fmt     = main_reg.fmt;
  assign out_imm     = main_reg.imm[XLEN-1:0];
  assign out_illegal = main_reg.illegal;

  // Upper imm bits are constant zero in narrow builds.
  generate
    if (XLEN < IMM_MAX) begin : g_imm_pad
      logic imm_pad_unused;
      assign imm_pad_unused = ^main_reg.imm[IMM_MAX-1:XLEN];
    end
  endgenerate

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed decode vectors on an
// XLEN=32/SYSTEM-enabled and an XLEN=64/SYSTEM-disabled instance, plus
// backpressure, flush and asynchronous reset sequences.
module tb_rv_decode_stage;
  import rv_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready, out_valid, out_illegal;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  fmt_e        out_fmt;
  logic [31:0] out_imm;

  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [6:0]  w_out_opcode, w_out_funct7;
  logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
  logic [2:0]  w_out_funct3;
  fmt_e        w_out_fmt;
  logic [63:0] w_out_imm;

  rv_decode_stage #(.XLEN(32), .FLAG_SYSTEM(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  rv_decode_stage #(.XLEN(64), .FLAG_SYSTEM(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_opcode(w_out_opcode), .out_rd(w_out_rd), .out_rs1(w_out_rs1),
    .out_rs2(w_out_rs2), .out_funct3(w_out_funct3), .out_funct7(w_out_funct7),
    .out_fmt(w_out_fmt), .out_imm(w_out_imm), .out_illegal(w_out_illegal)
  );

  always #5 clk = ~clk;

  int pass_count  = 0;
  int check_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        ill;
    logic        ill64;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] addi_k(input int k);
    logic [31:0] w;
    w = 32'h0000_0013 | (32'(k) << 20);
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hFFF10093, 3'd1, 5'd1,  5'd2,  5'd31, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[1] = '{32'h00112623, 3'd2, 5'd12, 5'd2,  5'd1,  3'd2, 7'h00, 64'h0000_0000_0000_000C, 1'b0, 1'b0};
    vecs[2] = '{32'hFE000EE3, 3'd3, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0};
    vecs[3] = '{32'h123452B7, 3'd4, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 64'h0000_0000_1234_5000, 1'b0, 1'b0};
    vecs[4] = '{32'h800002B7, 3'd4, 5'd5,  5'd0,  5'd0,  3'd0, 7'h40, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0};
    vecs[5] = '{32'h00000000, 3'd7, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 64'h0,                   1'b1, 1'b1};
    vecs[6] = '{32'h00000010, 3'd7, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 64'h0,                   1'b1, 1'b1};
    vecs[7] = '{32'hC0002573, 3'd1, 5'd10, 5'd0,  5'd0,  3'd2, 7'h60, 64'hFFFF_FFFF_FFFF_FC00, 1'b0, 1'b1};
    vecs[8] = '{32'h002081B3, 3'd0, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 64'h0,                   1'b0, 1'b0};
    vecs[9] = '{32'hFF9FF0EF, 3'd5, 5'd1,  5'd31, 5'd25, 3'd7, 7'h7F, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_imm", 64'(out_imm), 64'd0);
    check("reset_opcode", 64'(out_opcode), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven decode: one word at a time, latency 1.
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      logic [6:0] exp_op;
      v = vecs[i];
      exp_op = v.instr[6:0];
      @(negedge clk);
      check("idle_before_accept", 64'(out_valid), 64'd0);
      in_valid = 1'b1;
      in_instr = v.instr;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      $display("vec %0d instr=0x%08h fmt=%0d imm=0x%0h illegal=%0d | x64 fmt=%0d imm=0x%0h illegal=%0d",
               i, v.instr, out_fmt, out_imm, out_illegal, w_out_fmt, w_out_imm, w_out_illegal);
      check("lat1_out_valid", 64'(out_valid), 64'd1);
      check("opcode", 64'(out_opcode), 64'(exp_op));
      check("rd", 64'(out_rd), 64'(v.rd));
      check("rs1", 64'(out_rs1), 64'(v.rs1));
      check("rs2", 64'(out_rs2), 64'(v.rs2));
      check("funct3", 64'(out_funct3), 64'(v.f3));
      check("funct7", 64'(out_funct7), 64'(v.f7));
      check("fmt", 64'(out_fmt), 64'(v.fmt));
      check("imm32", 64'(out_imm), 64'(v.imm[31:0]));
      check("illegal", 64'(out_illegal), 64'(v.ill));
      check("x64_valid", 64'(w_out_valid), 64'd1);
      check("x64_rd", 64'(w_out_rd), 64'(v.rd));
      check("x64_fmt", 64'(w_out_fmt), v.ill64 ? 64'd7 : 64'(v.fmt));
      check("x64_imm", w_out_imm, v.ill64 ? 64'd0 : v.imm);
      check("x64_illegal", 64'(w_out_illegal), 64'(v.ill64));
      @(posedge clk);
    end

    // Backpressure: 6 words, out_ready low for cycles 2..4.
    begin : bp
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic stalled_prev = 1'b0;
      logic saw_full = 1'b0;
      logic [31:0] snap_imm = '0;
      logic [4:0]  snap_rs1 = '0;
      while (got < 6 && cyc < 60) begin
        @(negedge clk);
        out_ready = !(cyc >= 2 && cyc <= 4);
        in_valid  = (sent < 6);
        in_instr  = addi_k(sent + 1);
        #1;
        if (stalled_prev) begin
          check("bp_hold_valid", 64'(out_valid), 64'd1);
          check("bp_hold_imm", 64'(out_imm), 64'(snap_imm));
          check("bp_hold_rs1", 64'(out_rs1), 64'(snap_rs1));
        end
        if (cyc == 3) check("bp_ready_low_after_2", 64'(in_ready), 64'd0);
        if (!in_ready) saw_full = 1'b1;
        if (out_valid && out_ready) begin
          $display("bp cycle %0d out imm=%0d (expect %0d)", cyc, out_imm, got + 1);
          check("bp_order", 64'(out_imm), 64'(got + 1));
          got++;
        end
        stalled_prev = out_valid && !out_ready;
        snap_imm = out_imm;
        snap_rs1 = out_rs1;
        if (in_valid && in_ready) sent++;
        cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("bp_all_received", 64'(got), 64'd6);
      check("bp_saw_in_ready_low", 64'(saw_full), 64'd1);
      check("bp_drained", 64'(out_valid), 64'd0);
    end

    // Flush with main + skid full and a word offered in the same cycle.
    begin : fl
      int seen = 0;
      out_ready = 1'b0;
      @(negedge clk); in_valid = 1'b1; in_instr = addi_k(100);
      @(negedge clk); in_instr = addi_k(101);
      @(negedge clk);
      #1;
      check("flush_pre_valid", 64'(out_valid), 64'd1);
      check("flush_pre_ready", 64'(in_ready), 64'd0);
      flush = 1'b1; in_instr = addi_k(102);
      @(posedge clk);
      #1;
      $display("flush: out_valid=%0d in_ready=%0d", out_valid, in_ready);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("flush_nothing_emerges", 64'(seen), 64'd0);

      // Flush beats an accept while the stage is empty.
      @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_instr = addi_k(103);
      @(posedge clk);
      #1;
      check("flush_beats_accept", 64'(out_valid), 64'd0);
      @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    end

    // Asynchronous reset while an entry is stalled at the output.
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h123452B7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: out_valid=%0d in_ready=%0d imm=0x%0h", out_valid, in_ready, out_imm);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_ready", 64'(in_ready), 64'd1);
    check("async_rst_imm", 64'(out_imm), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
